// File: rtl/sipo_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx_pkg
//   Shared types and helpers for the sipo_frame_rx serial-to-parallel frame
//   receiver and its shift core.
//
//   Contents:
//     state_t       receive FSM states (data bits, trailing parity bit)
//     PARITY_EVEN   XOR over data + parity bits expected for a good frame
//     clog2_w()     bit-counter width able to hold the value WIDTH
// ---------------------------------------------------------------------------
package sipo_frame_rx_pkg;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    // Even parity: data bits plus the parity bit must XOR to zero.
    localparam logic PARITY_EVEN = 1'b0;

    // Counter must represent 0..WIDTH, hence WIDTH+1 distinct values.
    function automatic int clog2_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_rx_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx_shift_core
//   Shift register plus bit counter for the SIPO frame receiver. Captures one
//   serial bit per qualified cycle and flags the cycle on which the last data
//   bit of a frame is sampled.
//
//   Parameters:
//     WIDTH      data bits per frame (>= 2)
//     MSB_FIRST  1: shift left, first bit ends in [WIDTH-1]
//                0: shift right, first bit ends in [0]
//
//   Ports:
//     i_clk         clock, rising edge
//     i_rst_n       asynchronous active-low reset
//     i_clear       synchronous abort: counter and shift register to zero
//     i_serial_in   serial data bit
//     i_bit_valid   qualifies i_serial_in
//     i_shift_en    1 while data bits are expected (0 during a parity bit)
//     o_word        frame word including this cycle's bit when shifting,
//                   otherwise the held shift register contents
//     o_frame_done  pulse: the last data bit is being sampled this cycle
//     o_busy        bit counter is non-zero (frame partially received)
// ---------------------------------------------------------------------------
module sipo_frame_rx_shift_core
    import sipo_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_serial_in,
    input  logic             i_bit_valid,
    input  logic             i_shift_en,
    output logic [WIDTH-1:0] o_word,
    output logic             o_frame_done,
    output logic             o_busy
);

    localparam int            CW       = clog2_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_capture;
    logic             w_last;

    // Direction of shift decides where the first received bit ends up.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], i_serial_in};
        end else begin : g_lsb_first
            assign w_shift_next = {i_serial_in, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // A clear in the same cycle as a bit discards that bit.
    assign w_capture    = i_bit_valid & i_shift_en & ~i_clear;
    assign w_last       = (r_count == LAST_IDX);
    assign o_frame_done = w_capture & w_last;
    assign o_busy       = (r_count != '0);

    // Forwarding the next value lets the top load the frame on the same edge
    // that samples the final bit, giving one cycle of latency.
    assign o_word = i_shift_en ? w_shift_next : r_shift;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_capture) begin
            r_shift <= w_shift_next;
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// ---------------------------------------------------------------------------
// sipo_frame_rx
//   Parametrised serial-in/parallel-out frame receiver. Collects WIDTH
//   qualified serial bits into a frame, presents it on a held output register
//   with a valid/ready handshake, and raises a sticky overrun flag when a
//   completed frame has to be dropped because the output slot is occupied.
//
//   Optional feature macro: SIPO_PARITY_EN
//     defined   - an even-parity bit follows every WIDTH data bits, and
//                 o_parity_err reports a bad frame alongside o_parallel_out
//     undefined - a frame is exactly WIDTH bits, no o_parity_err port
//
//   Parameters:
//     WIDTH      data bits per frame (>= 2)
//     MSB_FIRST  1: first received bit in o_parallel_out[WIDTH-1], 0: in [0]
//
//   Ports:
//     i_clk           clock, rising edge
//     i_rst_n         asynchronous active-low reset
//     i_clear         sync abort of the current frame, clears overrun
//     i_serial_in     serial data bit
//     i_bit_valid     qualifies i_serial_in
//     i_out_ready     consumer accepts when o_out_valid & i_out_ready
//     o_parallel_out  completed frame, frozen while o_out_valid = 1
//     o_out_valid     frame available
//     o_overrun       sticky: a completed frame was dropped
//     o_parity_err    (SIPO_PARITY_EN only) parity error of held frame
//     o_busy          frame partially received
// ---------------------------------------------------------------------------
module sipo_frame_rx
    import sipo_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_serial_in,
    input  logic             i_bit_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_parallel_out,
    output logic             o_out_valid,
    output logic             o_overrun,
`ifdef SIPO_PARITY_EN
    output logic             o_parity_err,
`endif
    output logic             o_busy
);

    logic [WIDTH-1:0] r_parallel_out;
    logic             r_out_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_core_word;
    logic             w_core_done;
    logic             w_core_busy;
    logic             w_shift_en;
    logic             w_complete;
    logic             w_slot_free;

`ifdef SIPO_PARITY_EN
    state_t           r_state;
    logic             r_parity_err;
    logic             w_parity_err;

    // Data bits are only shifted in while the FSM expects data.
    assign w_shift_en   = (r_state == ST_DATA);
    // The frame is complete when the parity bit itself is sampled.
    assign w_complete   = (r_state == ST_PARITY) & i_bit_valid & ~i_clear;
    assign w_parity_err = ((^w_core_word) ^ i_serial_in) != PARITY_EVEN;
    assign o_parity_err = r_parity_err;
    // The counter has already wrapped while waiting for parity.
    assign o_busy       = w_core_busy | (r_state == ST_PARITY);
`else
    assign w_shift_en   = 1'b1;
    assign w_complete   = w_core_done;
    assign o_busy       = w_core_busy;
`endif

    // A frame can be loaded when the slot is empty or is being emptied now.
    assign w_slot_free = ~r_out_valid | i_out_ready;

    assign o_parallel_out = r_parallel_out;
    assign o_out_valid    = r_out_valid;
    assign o_overrun      = r_overrun;

    sipo_frame_rx_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_core (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (i_clear),
        .i_serial_in  (i_serial_in),
        .i_bit_valid  (i_bit_valid),
        .i_shift_en   (w_shift_en),
        .o_word       (w_core_word),
        .o_frame_done (w_core_done),
        .o_busy       (w_core_busy)
    );

    // Receive FSM, output holding register, handshake and overrun tracking.
    // A clear never touches the held frame or out_valid; it only aborts the
    // frame in progress and drops the sticky overrun flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parallel_out <= '0;
            r_out_valid    <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_state        <= ST_DATA;
            r_parity_err   <= 1'b0;
`endif
        end else begin
`ifdef SIPO_PARITY_EN
            if (i_clear) begin
                r_state <= ST_DATA;
            end else if (r_state == ST_DATA && w_core_done) begin
                r_state <= ST_PARITY;
            end else if (r_state == ST_PARITY && i_bit_valid) begin
                r_state <= ST_DATA;
            end
`endif
            if (w_complete) begin
                if (w_slot_free) begin
                    r_parallel_out <= w_core_word;
                    r_out_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
                    r_parity_err   <= w_parity_err;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (i_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
